wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Registered, parametrised writeback stage for the pipelined xgriscv core; successor to the single-cycle combinational writeback select.
- Captures the MEM-stage result bundle and selects the writeback data from one of four sources: ALU, MEM, PC+PCINC, IMM.
- MEM-source data is load-aligned and sign- or zero-extended.
- Drives the register-file write port; the same registered bundle serves as the WB-to-EX forwarding source.

Parameters:
- XLEN, 32, datapath width in bits; supported values 32 or 64.
- RADDR, 5, register address width.
- PCINC, 4, PC increment used for the FromPC source (link value).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM-stage bundle is valid this cycle.
- stall  in  1  hold the stage register.
- flush  in  1  replace the stage contents with a bubble.
- wdsel  in  2  source select, encoded with WDSel_* constants.
- regwrite  in  1  instruction writes rd.
- rd  in  RADDR  destination register.
- aluout  in  XLEN  ALU result; its low bits are also the load byte address.
- memdout  in  XLEN  raw memory read word.
- pc  in  XLEN  instruction PC.
- immout  in  XLEN  immediate (LUI).
- ldtype  in  3  load type, encoded with LD_* constants.
- wb_valid  out  1  stage holds a valid instruction.
- wb_we  out  1  register-file write enable.
- wb_rd  out  RADDR  register-file write address.
- wb_wd  out  XLEN  register-file write data.

Behaviour:
- All outputs are registered. Latency is exactly 1 cycle from input capture to output.
- Every rising edge applies exactly one action, in this priority:
  1. reset: wb_valid=0, wb_we=0, wb_rd=0, wb_wd=0.
  2. flush: same values as reset (bubble). flush overrides stall in the same cycle.
  3. stall: all outputs hold their previous values; inputs are ignored.
  4. Otherwise load:
     - wb_valid <= in_valid
     - wb_rd <= rd
     - wb_we <= in_valid & regwrite & (rd != 0); writes to x0 are always suppressed.
     - wb_wd <= the selected source value.
     - When in_valid=0, wb_wd <= 0.
- Source select:
  - FromALU: aluout.
  - FromMEM: load-extended memdout.
  - FromPC: pc + PCINC, modulo 2^XLEN; 0xFFFFFFFC + 4 wraps to 0.
  - FromIMM: immout.
- Load extension for FromMEM; the byte offset is aluout[1:0] (aluout[2:0] when XLEN=64):
  - LB/LBU: select the addressed byte; sign- or zero-extend to XLEN.
  - LH/LHU: select the addressed halfword via offset[1] (offset[2:1] when XLEN=64); sign- or zero-extend.
  - LW: select the addressed word via offset[2] when XLEN=64; sign-extend. When XLEN=32 this is the word unchanged.
  - LWU (XLEN=64 only): zero-extend the selected word.
  - LD (XLEN=64 only): full doubleword.
  - LWU or LD with XLEN=32: treated as LW.
  - Misaligned halfword/word offsets are not checked here. The offset's low bits are ignored and the aligned container is used.
- Undefined ldtype codes behave as LW.
- No internal state beyond the output register. A flush while stalled (mid-stall) takes effect on that edge; the previously held instruction is dropped.

Decomposition:
- Shared defines, added to the existing defines file:
  - WDSel_FromALU=2'b00, WDSel_FromMEM=2'b01, WDSel_FromPC=2'b10, WDSel_FromIMM=2'b11 (new).
  - LD_LB=3'b000, LD_LH=3'b001, LD_LW=3'b010, LD_LD=3'b011, LD_LBU=3'b100, LD_LHU=3'b101, LD_LWU=3'b110.
- One sub-module: load_ext (combinational; parameters XLEN; ports memdout, offset, ldtype -> extended data). It is instantiated once and is reusable by a future load-forwarding path.

Test Plan:
- reset=1 for 2 cycles with random inputs -> all outputs 0. Release reset with in_valid=1, wdsel=FromALU, aluout=0x12345678, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_wd=0x12345678.
- wdsel=FromMEM, memdout=0x80F1_7F82:
  - LB, aluout=0x1000 -> wb_wd=0xFFFFFF82.
  - LBU, aluout=0x1003 -> wb_wd=0x00000080.
  - LH, aluout=0x1002 -> wb_wd=0xFFFF80F1.
  - LHU, aluout=0x1002 -> wb_wd=0x000080F1.
- wdsel=FromPC, pc=0x0000_0100 -> wb_wd=0x104. pc=0xFFFF_FFFC -> wb_wd=0x0. wdsel=FromIMM, immout=0xABCDE000 -> wb_wd=0xABCDE000.
- rd=0, regwrite=1, in_valid=1 -> wb_valid=1, wb_we=0. in_valid=0, regwrite=1, rd=7 -> wb_valid=0, wb_we=0.
- Load instruction A, then stall=1 for 3 cycles while presenting B -> outputs hold A for all 3 cycles. Release stall -> B appears on the next edge.
- stall=1 and flush=1 asserted together while holding A -> next edge gives a bubble (all outputs 0). Same test with XLEN=64: LWU, memdout=0x8000_0000_FFFF_FFFF, aluout offset 4 -> wb_wd=0x0000_0000_8000_0000.

Source files
------------

// File: rtl/wb_select_stage_pkg.sv
// Shared writeback-stage definitions for the xgriscv core.
//   WDSel_* : writeback source select encodings (wdsel).
//   LD_*    : load type encodings (ldtype).
//   ld_off_width() : width of the load byte offset for a given datapath width.
package wb_select_stage_pkg;

   localparam logic [1:0] WDSel_FromALU = 2'b00;
   localparam logic [1:0] WDSel_FromMEM = 2'b01;
   localparam logic [1:0] WDSel_FromPC  = 2'b10;
   localparam logic [1:0] WDSel_FromIMM = 2'b11;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LD  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;
   localparam logic [2:0] LD_LWU = 3'b110;

   // Byte offset within one XLEN-wide memory word.
   function automatic int unsigned ld_off_width(input int unsigned xlen);
      return (xlen == 64) ? 3 : 2;
   endfunction

endpackage

// File: rtl/wb_select_stage_load_ext.sv
// load_ext: combinational load alignment and sign/zero extension.
//   memdout  in  XLEN  raw memory read word
//   offset   in  OffW  byte offset of the access within the word
//   ldtype   in  3     LD_* load type
//   ext_data out XLEN  aligned, extended load data
// Misaligned halfword/word offsets fall back to the aligned container.
module load_ext
   import wb_select_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   localparam int unsigned OffW = ld_off_width(XLEN)
) (
   input  logic [XLEN-1:0] memdout,
   input  logic [OffW-1:0] offset,
   input  logic [2:0]      ldtype,
   output logic [XLEN-1:0] ext_data
);

   // Only a 64-bit datapath has two words per memory word to choose from.
   localparam logic [OffW-1:0] WordSel = OffW'((XLEN == 64) ? 4 : 0);

   logic [OffW-1:0] half_off;
   logic [OffW-1:0] word_off;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [31:0]     word_v;

   always_comb begin
      half_off = {offset[OffW-1:1], 1'b0};
      word_off = offset & WordSel;
      byte_v   = memdout[{offset, 3'b000} +: 8];
      half_v   = memdout[{half_off, 3'b000} +: 16];
      word_v   = memdout[{word_off, 3'b000} +: 32];
   end

   always_comb begin
      ext_data = XLEN'($signed(word_v));
      case (ldtype)
         LD_LB:  ext_data = XLEN'($signed(byte_v));
         LD_LBU: ext_data = XLEN'(byte_v);
         LD_LH:  ext_data = XLEN'($signed(half_v));
         LD_LHU: ext_data = XLEN'(half_v);
         LD_LWU: ext_data = (XLEN == 64) ? XLEN'(word_v) : XLEN'($signed(word_v));
         LD_LD:  ext_data = (XLEN == 64) ? memdout : XLEN'($signed(word_v));
         default: ext_data = XLEN'($signed(word_v)); // LW and undefined codes
      endcase
   end

endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback stage. Captures the MEM-stage bundle,
// selects the writeback data and drives the register-file write port; the
// registered bundle doubles as the WB-to-EX forwarding source.
//   clk, reset                    clock, synchronous active-high reset
//   in_valid, stall, flush        bundle valid, hold stage, insert bubble
//   wdsel, regwrite, rd           source select, rd write, destination
//   aluout, memdout, pc, immout   candidate sources (aluout also load address)
//   ldtype                        load type for the MEM source
//   wb_valid, wb_we, wb_rd, wb_wd registered writeback bundle
module wb_select_stage
   import wb_select_stage_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RADDR = 5,
   parameter int unsigned PCINC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [1:0]       wdsel,
   input  logic             regwrite,
   input  logic [RADDR-1:0] rd,
   input  logic [XLEN-1:0]  aluout,
   input  logic [XLEN-1:0]  memdout,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  immout,
   input  logic [2:0]       ldtype,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [RADDR-1:0] wb_rd,
   output logic [XLEN-1:0]  wb_wd
);

   localparam int unsigned OffW = ld_off_width(XLEN);

   logic             valid_q, valid_d;
   logic             we_q, we_d;
   logic [RADDR-1:0] rd_q, rd_d;
   logic [XLEN-1:0]  wd_q, wd_d;
   logic [XLEN-1:0]  load_data;
   logic [XLEN-1:0]  sel_data;

   load_ext #(
      .XLEN (XLEN)
   ) u_load_ext (
      .memdout  (memdout),
      .offset   (aluout[OffW-1:0]),
      .ldtype   (ldtype),
      .ext_data (load_data)
   );

   always_comb begin
      sel_data = aluout;
      case (wdsel)
         WDSel_FromALU: sel_data = aluout;
         WDSel_FromMEM: sel_data = load_data;
         WDSel_FromPC:  sel_data = pc + XLEN'(PCINC); // wraps modulo 2^XLEN
         WDSel_FromIMM: sel_data = immout;
         default:       sel_data = aluout;
      endcase
   end

   // Flush beats stall; a stalled stage ignores its inputs.
   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      rd_d    = rd_q;
      wd_d    = wd_q;
      if (flush) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
         rd_d    = '0;
         wd_d    = '0;
      end else if (!stall) begin
         valid_d = in_valid;
         we_d    = in_valid & regwrite & (rd != '0); // x0 is never written
         rd_d    = rd;
         wd_d    = in_valid ? sel_data : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         rd_q    <= '0;
         wd_q    <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         wd_q    <= wd_d;
      end
   end

   assign wb_valid = valid_q;
   assign wb_we    = we_q;
   assign wb_rd    = rd_q;
   assign wb_wd    = wd_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: a 32-bit and a 64-bit instance share stimulus and
// are compared each cycle against a behavioural model of the writeback bundle.
module tb_wb_select_stage;

   logic        clk;
   logic        reset, in_valid, stall, flush, regwrite;
   logic [1:0]  wdsel;
   logic [4:0]  rd;
   logic [63:0] aluout, memdout, pc, immout;
   logic [2:0]  ldtype;

   logic        wb_valid32, wb_we32, wb_valid64, wb_we64;
   logic [4:0]  wb_rd32, wb_rd64;
   logic [31:0] wb_wd32;
   logic [63:0] wb_wd64;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        valid;
      logic        we;
      logic [4:0]  rd;
      logic [63:0] wd;
   } st_t;

   st_t e32, e64;

   wb_select_stage #(.XLEN(32), .RADDR(5), .PCINC(4)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .wdsel(wdsel), .regwrite(regwrite), .rd(rd), .aluout(aluout[31:0]),
      .memdout(memdout[31:0]), .pc(pc[31:0]), .immout(immout[31:0]), .ldtype(ldtype),
      .wb_valid(wb_valid32), .wb_we(wb_we32), .wb_rd(wb_rd32), .wb_wd(wb_wd32)
   );

   wb_select_stage #(.XLEN(64), .RADDR(5), .PCINC(4)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .wdsel(wdsel), .regwrite(regwrite), .rd(rd), .aluout(aluout),
      .memdout(memdout), .pc(pc), .immout(immout), .ldtype(ldtype),
      .wb_valid(wb_valid64), .wb_we(wb_we64), .wb_rd(wb_rd64), .wb_wd(wb_wd64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Load result from access size, signedness and the aligned container.
   function automatic logic [63:0] model_load(input int xlen, input logic [63:0] mem,
                                              input logic [63:0] addr, input logic [2:0] lt);
      int nbytes, off, size, base;
      bit sgn;
      logic [63:0] mask, v, lim;
      nbytes = xlen / 8;
      mask   = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      off    = int'(addr[2:0]) % nbytes;
      case (lt)
         3'd0: begin size = 1; sgn = 1; end
         3'd4: begin size = 1; sgn = 0; end
         3'd1: begin size = 2; sgn = 1; end
         3'd5: begin size = 2; sgn = 0; end
         3'd6: begin size = 4; sgn = (xlen == 32); end
         3'd3: begin size = (xlen == 64) ? 8 : 4; sgn = (xlen == 32); end
         default: begin size = 4; sgn = 1; end
      endcase
      base = off - (off % size);
      v = (mem & mask) >> (8 * base);
      if (size < 8) begin
         lim = (64'd1 << (8 * size)) - 64'd1;
         v = v & lim;
         if (sgn && v[8 * size - 1]) v = v | ~lim;
      end
      return v & mask;
   endfunction

   function automatic st_t model_next(input st_t cur, input int xlen);
      st_t n;
      logic [63:0] mask;
      mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      if (reset || flush) return '0;
      if (stall) return cur;
      n.valid = in_valid;
      n.rd    = rd;
      n.we    = in_valid && regwrite && (rd != 5'd0);
      if (!in_valid) n.wd = 64'd0;
      else begin
         case (wdsel)
            2'd0: n.wd = aluout & mask;
            2'd1: n.wd = model_load(xlen, memdout, aluout, ldtype);
            2'd2: n.wd = (pc + 64'd4) & mask;
            default: n.wd = immout & mask;
         endcase
      end
      return n;
   endfunction

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      cmp({tag, " valid32"}, 64'(wb_valid32), 64'(e32.valid));
      cmp({tag, " we32"},    64'(wb_we32),    64'(e32.we));
      cmp({tag, " rd32"},    64'(wb_rd32),    64'(e32.rd));
      cmp({tag, " wd32"},    64'(wb_wd32),    e32.wd);
      cmp({tag, " valid64"}, 64'(wb_valid64), 64'(e64.valid));
      cmp({tag, " we64"},    64'(wb_we64),    64'(e64.we));
      cmp({tag, " rd64"},    64'(wb_rd64),    64'(e64.rd));
      cmp({tag, " wd64"},    wb_wd64,         e64.wd);
   endtask

   // Inputs are stable here; apply one edge to the model and the DUTs.
   task automatic tick(input string tag);
      e32 = model_next(e32, 32);
      e64 = model_next(e64, 64);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic rand_inputs();
      in_valid = 1'($urandom);
      regwrite = 1'($urandom);
      wdsel    = 2'($urandom);
      rd       = 5'($urandom);
      ldtype   = 3'($urandom);
      aluout   = {$urandom, $urandom};
      memdout  = {$urandom, $urandom};
      pc       = {$urandom, $urandom};
      immout   = {$urandom, $urandom};
   endtask

   initial begin
      e32 = '0;
      e64 = '0;
      stall = 1'b0;
      flush = 1'b0;
      reset = 1'b1;
      rand_inputs();
      #1;
      tick("reset0");
      rand_inputs();
      tick("reset1");
      cmp("reset wd32 zero", 64'(wb_wd32), 64'd0);
      cmp("reset valid64 zero", 64'(wb_valid64), 64'd0);

      reset = 1'b0; in_valid = 1'b1; wdsel = 2'b00; regwrite = 1'b1; rd = 5'd5;
      aluout = 64'h1234_5678;
      tick("alu");
      cmp("alu literal wd32", 64'(wb_wd32), 64'h1234_5678);
      cmp("alu literal we32", 64'(wb_we32), 64'd1);

      wdsel = 2'b01; memdout = 64'h0000_0000_80F1_7F82;
      ldtype = 3'b000; aluout = 64'h1000; tick("lb");
      cmp("lb literal", 64'(wb_wd32), 64'hFFFF_FF82);
      ldtype = 3'b100; aluout = 64'h1003; tick("lbu");
      cmp("lbu literal", 64'(wb_wd32), 64'h0000_0080);
      ldtype = 3'b001; aluout = 64'h1002; tick("lh");
      cmp("lh literal", 64'(wb_wd32), 64'hFFFF_80F1);
      ldtype = 3'b101; aluout = 64'h1002; tick("lhu");
      cmp("lhu literal", 64'(wb_wd32), 64'h0000_80F1);
      ldtype = 3'b111; aluout = 64'h1001; tick("undef ldtype");

      wdsel = 2'b10; pc = 64'h100; tick("pc");
      cmp("pc literal", 64'(wb_wd32), 64'h104);
      pc = 64'hFFFF_FFFC; tick("pc wrap");
      cmp("pc wrap literal", 64'(wb_wd32), 64'h0);
      wdsel = 2'b11; immout = 64'hABCD_E000; tick("imm");
      cmp("imm literal", 64'(wb_wd32), 64'hABCD_E000);

      rd = 5'd0; tick("rd x0");
      cmp("x0 we literal", 64'(wb_we32), 64'd0);
      in_valid = 1'b0; rd = 5'd7; tick("invalid");
      cmp("invalid valid literal", 64'(wb_valid64), 64'd0);

      // Hold A across three stalled edges while B is presented.
      in_valid = 1'b1; wdsel = 2'b00; rd = 5'd9; aluout = 64'hAAAA; tick("A");
      stall = 1'b1; rd = 5'd10; aluout = 64'hBBBB;
      for (int i = 0; i < 3; i++) begin
         tick("stall");
         cmp("stall hold literal", 64'(wb_wd32), 64'hAAAA);
      end
      stall = 1'b0; tick("B");
      cmp("B literal", 64'(wb_wd32), 64'hBBBB);

      stall = 1'b1; flush = 1'b1; tick("stall+flush");
      cmp("flush literal valid", 64'(wb_valid32), 64'd0);
      stall = 1'b0; flush = 1'b0;

      wdsel = 2'b01; ldtype = 3'b110; memdout = 64'h8000_0000_FFFF_FFFF; aluout = 64'h4;
      tick("lwu");
      cmp("lwu64 literal", wb_wd64, 64'h0000_0000_8000_0000);
      cmp("lwu32 as lw literal", 64'(wb_wd32), 64'hFFFF_FFFF);
      ldtype = 3'b011; tick("ld");
      cmp("ld64 literal", wb_wd64, 64'h8000_0000_FFFF_FFFF);

      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         reset = ($urandom_range(0, 31) == 0);
         flush = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         tick("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
